tinyqv_multi_timer: RTL and testbench

Multi-channel down-counting timer peripheral for the tinyQV SoC, replacing the single fixed timer. It provides NUM_CH independent channels sharing one programmable prescaler, each with one-shot or auto-reload mode and a sticky interrupt flag. It sits on the tinyQV peripheral register bus, and its per-channel IRQ lines feed the CPU interrupt inputs.

---
 rtl/tinyqv_multi_timer.sv | 172 +++++++++++++++++
 tb/tb_tinyqv_multi_timer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/tinyqv_multi_timer.sv
`default_nettype none
// ============================================================================
// Module   : tinyqv_multi_timer
// Brief    : NUM_CH-channel down-counting timer with a shared prescaler,
//            one-shot / auto-reload modes and sticky per-channel interrupts,
//            accessed over the tinyQV peripheral register bus.
// Revision : 1.0 - initial release
// ============================================================================
module tinyqv_multi_timer #(
    parameter int NUM_CH  = 4,
    parameter int WIDTH   = 32,
    parameter int PRESC_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        addr,
    input  logic [31:0]       data_in,
    input  logic              data_write,
    input  logic              data_read,
    output logic [31:0]       data_out,
    output logic [NUM_CH-1:0] irq,
    output logic              irq_any
);

    // Channel index NUM_CH addresses the global register block.
    localparam logic [3:0]       c_GLOBAL = 4'(NUM_CH);
    localparam logic [WIDTH-1:0] c_ONE    = WIDTH'(1);

    localparam logic [1:0] c_REG_COUNT  = 2'd0;
    localparam logic [1:0] c_REG_RELOAD = 2'd1;
    localparam logic [1:0] c_REG_CTRL   = 2'd2;
    localparam logic [1:0] c_REG_STATUS = 2'd3;

    localparam logic [1:0] c_GREG_PRESCALE = 2'd0;
    localparam logic [1:0] c_GREG_PENDING  = 2'd1;

    // Register state
    logic [WIDTH-1:0]   r_count  [NUM_CH];
    logic [WIDTH-1:0]   r_reload [NUM_CH];
    logic [NUM_CH-1:0]  r_en;
    logic [NUM_CH-1:0]  r_auto;
    logic [NUM_CH-1:0]  r_irq_en;
    logic [NUM_CH-1:0]  r_pending;
    logic [PRESC_W-1:0] r_prescale;
    logic [PRESC_W-1:0] r_presc_cnt;

    // Decode
    logic [3:0]        w_ch;
    logic [1:0]        w_reg;
    logic              w_glob_wr;
    logic [NUM_CH-1:0] w_ch_wr;
    logic [NUM_CH-1:0] w_fire;
    logic              w_tick;
    logic [31:0]       w_rd_data;

    assign w_ch      = addr[5:2];
    assign w_reg     = addr[1:0];
    assign w_glob_wr = data_write && (w_ch == c_GLOBAL);

    // The prescaler terminal count is the tick; PRESCALE=0 ticks every clock.
    assign w_tick = (r_presc_cnt == r_prescale);

    // Per-channel write select and fire detection; a COUNT write on the same
    // cycle overrides the countdown, so it also suppresses the fire.
    always_comb begin
        w_ch_wr = '0;
        w_fire  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_ch_wr[i] = data_write && (w_ch == 4'(i));
            w_fire[i]  = w_tick && r_en[i] && (r_count[i] == c_ONE) &&
                         !(w_ch_wr[i] && (w_reg == c_REG_COUNT));
        end
    end

    // Global registers and the free-running prescaler counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prescale  <= '0;
            r_presc_cnt <= '0;
        end else if (w_glob_wr && (w_reg == c_GREG_PRESCALE)) begin
            r_prescale  <= data_in[PRESC_W-1:0];
            r_presc_cnt <= '0;
        end else if (w_tick) begin
            r_presc_cnt <= '0;
        end else begin
            r_presc_cnt <= r_presc_cnt + PRESC_W'(1);
        end
    end

    // Channel registers: bus writes take priority over the countdown, and the
    // countdown uses the enable held before this edge so a CTRL write that
    // enables a channel never decrements in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_count[i]  <= '0;
                r_reload[i] <= '0;
            end
            r_en      <= '0;
            r_auto    <= '0;
            r_irq_en  <= '0;
            r_pending <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_ch_wr[i] && (w_reg == c_REG_COUNT)) begin
                    r_count[i] <= data_in[WIDTH-1:0];
                end else if (w_tick && r_en[i] && (r_count[i] != '0)) begin
                    if (r_count[i] == c_ONE) begin
                        r_count[i] <= r_auto[i] ? r_reload[i] : '0;
                    end else begin
                        r_count[i] <= r_count[i] - c_ONE;
                    end
                end

                if (w_ch_wr[i] && (w_reg == c_REG_RELOAD)) begin
                    r_reload[i] <= data_in[WIDTH-1:0];
                end

                if (w_ch_wr[i] && (w_reg == c_REG_CTRL)) begin
                    r_en[i]     <= data_in[0];
                    r_auto[i]   <= data_in[1];
                    r_irq_en[i] <= data_in[2];
                end

                // A new fire beats a simultaneous write-1-to-clear.
                if (w_fire[i]) begin
                    r_pending[i] <= 1'b1;
                end else if (w_ch_wr[i] && (w_reg == c_REG_STATUS) && data_in[0]) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    // Read data selection; unmapped addresses return zero.
    always_comb begin
        w_rd_data = '0;
        if (w_ch == c_GLOBAL) begin
            case (w_reg)
                c_GREG_PRESCALE: w_rd_data = 32'(r_prescale);
                c_GREG_PENDING:  w_rd_data = 32'(r_pending);
                default:         w_rd_data = '0;
            endcase
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_ch == 4'(i)) begin
                    case (w_reg)
                        c_REG_COUNT:  w_rd_data = 32'(r_count[i]);
                        c_REG_RELOAD: w_rd_data = 32'(r_reload[i]);
                        c_REG_CTRL:   w_rd_data = {29'd0, r_irq_en[i], r_auto[i], r_en[i]};
                        c_REG_STATUS: w_rd_data = {31'd0, r_pending[i]};
                        default:      w_rd_data = '0;
                    endcase
                end
            end
        end
    end

    // Registered read port: captured on the strobe, held until the next read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
        end else if (data_read) begin
            data_out <= w_rd_data;
        end
    end

    assign irq     = r_pending & r_irq_en;
    assign irq_any = |irq;

endmodule
`default_nettype wire

// File: tb/tb_tinyqv_multi_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tinyqv_multi_timer
// Brief    : Self-checking bench for tinyqv_multi_timer. Register reads push
//            their expected value to a scoreboard; a monitor pops and compares
//            when data_out becomes valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tinyqv_multi_timer;

    localparam int NUM_CH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [5:0]        addr = '0;
    logic [31:0]       data_in = '0;
    logic              data_write = 1'b0;
    logic              data_read = 1'b0;
    logic [31:0]       data_out;
    logic [NUM_CH-1:0] irq;
    logic              irq_any;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic        rd_seen = 1'b0;

    tinyqv_multi_timer #(.NUM_CH(NUM_CH), .WIDTH(32), .PRESC_W(8)) dut (
        .clk(clk), .rst(rst), .addr(addr), .data_in(data_in),
        .data_write(data_write), .data_read(data_read), .data_out(data_out),
        .irq(irq), .irq_any(irq_any)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Channel/register address helper; channel NUM_CH is the global block.
    function automatic logic [5:0] a(input int ch, input int r);
        return 6'((ch << 2) | r);
    endfunction

    // All tasks start and end on a falling edge.
    task automatic wr(input logic [5:0] ad, input logic [31:0] d);
        addr = ad; data_in = d; data_write = 1'b1;
        @(posedge clk);
        @(negedge clk);
        data_write = 1'b0;
    endtask

    task automatic rd(input logic [5:0] ad, input logic [31:0] e, input string tag);
        addr = ad; data_read = 1'b1;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        @(negedge clk);
        data_read = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard: a read strobed at an edge has data_out valid by the next fall.
    always @(posedge clk) rd_seen <= data_read;

    always @(negedge clk) begin
        if (rd_seen) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                check(tag_q.pop_front(), data_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        int n;
        logic seen;

        // Reset state
        idle(2);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_dout", data_out, 32'd0);
        rst = 1'b0;
        idle(1);
        rd(a(0, 0), 32'd0, "rst_count0");
        rd(a(NUM_CH, 0), 32'd0, "rst_prescale");
        rd(a(1, 2), 32'd0, "rst_ctrl1");

        // Unmapped addresses: writes ignored, reads zero
        wr(a(NUM_CH, 2), 32'hFFFF_FFFF);
        rd(a(NUM_CH, 2), 32'd0, "unmapped_glob");
        rd(a(5, 0), 32'd0, "unmapped_ch5");

        // One-shot fire on COUNT=1
        wr(a(NUM_CH, 0), 32'd0);
        wr(a(0, 2), 32'h5);
        wr(a(0, 0), 32'd1);
        check("fire1_not_yet", 32'(irq), 32'd0);
        idle(1);
        check("fire1_irq", 32'(irq), 32'h1);
        check("fire1_irq_any", 32'(irq_any), 32'd1);
        rd(a(0, 0), 32'd0, "fire1_count");
        rd(a(NUM_CH, 1), 32'h1, "fire1_pending");
        rd(a(0, 3), 32'h1, "fire1_status");
        wr(a(0, 3), 32'h1);
        check("w1c_irq", 32'(irq), 32'd0);

        // COUNT=0 never fires
        wr(a(0, 0), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (irq != '0) seen = 1'b1;
        end
        check("zero_no_irq", 32'(seen), 32'd0);
        rd(a(0, 3), 32'd0, "zero_status");

        // Auto-reload 3,2,1,3...
        wr(a(0, 1), 32'd3);
        wr(a(0, 2), 32'h7);
        wr(a(0, 0), 32'd3);
        rd(a(0, 0), 32'd3, "ar_c3");
        rd(a(0, 0), 32'd2, "ar_c2");
        rd(a(0, 0), 32'd1, "ar_c1");
        rd(a(0, 0), 32'd3, "ar_reload");
        rd(a(0, 0), 32'd2, "ar_c2b");
        // W1C coincides with the next fire: set wins
        wr(a(0, 3), 32'h1);
        check("w1c_vs_fire_irq", 32'(irq), 32'h1);
        rd(a(0, 3), 32'h1, "w1c_vs_fire_status");
        wr(a(0, 3), 32'h1);
        check("rearm_cleared", 32'(irq), 32'd0);
        idle(1);
        check("rearm_fire", 32'(irq), 32'h1);
        // COUNT write coincides with a tick: write wins
        wr(a(0, 0), 32'd7);
        rd(a(0, 0), 32'd7, "cnt_wr_vs_tick");
        // Disable freezes the counter (the disabling edge still counts)
        wr(a(0, 2), 32'h0);
        rd(a(0, 0), 32'd5, "disable_count");
        rd(a(0, 0), 32'd5, "frozen_count");
        check("disable_keeps_pending", 32'(dut.r_pending[0]), 32'd1);
        check("irq_masked", 32'(irq), 32'd0);
        wr(a(0, 3), 32'h1);

        // Prescaler: PRESCALE=9, COUNT=5 on channel 2
        wr(a(0, 0), 32'd0);
        wr(a(0, 2), 32'h5);
        wr(a(1, 2), 32'h5);
        wr(a(3, 2), 32'h5);
        wr(a(NUM_CH, 0), 32'd9);
        wr(a(2, 0), 32'd5);
        wr(a(2, 2), 32'h5);
        wr(a(NUM_CH, 0), 32'd9);
        n = 1;
        while (!irq[2] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("presc_latency_in_range", 32'(n >= 49 && n <= 51), 32'd1);
        check("presc_others_idle", 32'(irq & 4'b1011), 32'd0);
        rd(a(2, 0), 32'd0, "presc_count_done");

        // Asynchronous reset mid-count
        wr(a(NUM_CH, 0), 32'd0);
        wr(a(1, 0), 32'd20);
        rd(a(0, 1), 32'd3, "pre_rst_reload");
        idle(3);
        check("pre_rst_irq", 32'(irq), 32'h4);
        #2 rst = 1'b1;
        #1;
        check("async_rst_irq", 32'(irq), 32'd0);
        check("async_rst_irq_any", 32'(irq_any), 32'd0);
        check("async_rst_dout", data_out, 32'd0);
        rst = 1'b0;
        idle(1);
        rd(a(1, 0), 32'd0, "post_rst_count");
        rd(a(NUM_CH, 1), 32'd0, "post_rst_pending");
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (irq != '0) seen = 1'b1;
        end
        check("post_rst_no_irq", 32'(seen), 32'd0);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
